// File: rtl/frame_uploader_pkg.sv
// Shared constants and FSM state encoding for the camera frame upload sequencer.
package frame_uploader_pkg;

  localparam logic [7:0] CMD_CAPTURE = 8'h43;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] SYNC0       = 8'hA5;
  localparam logic [7:0] SYNC1       = 8'h5A;
  localparam logic [7:0] ERR_CODE    = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CAP_START,
    ST_CAP_WAIT_HI,
    ST_CAP_WAIT_LO,
    ST_RD_START,
    ST_RRST_WAIT,
    ST_HDR0,
    ST_HDR1,
    ST_BYTE_REQ,
    ST_BYTE_WAIT,
    ST_BYTE_TX,
    ST_CSUM_H,
    ST_CSUM_L,
    ST_ERR_TX
  } state_t;

endpackage

// File: rtl/uart_byte_issue.sv
// Single-byte UART handshake: wait for an idle transmitter, pulse tx_en with the
// byte latched, then report completion on the tx_done pulse.
module uart_byte_issue (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_req,
  input  logic [7:0] i_data,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_done
);

  logic       r_inflight;
  logic       r_tx_en;
  logic [7:0] r_tx_data;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_inflight <= 1'b0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_en <= 1'b0;
      if (!r_inflight) begin
        if (i_req && !i_tx_busy) begin
          r_inflight <= 1'b1;
          r_tx_en    <= 1'b1;
          r_tx_data  <= i_data;
        end
      end else if (i_tx_done) begin
        r_inflight <= 1'b0;
      end
    end
  end

  // Combinational so the requester advances on the very edge that sees tx_done.
  assign o_done    = r_inflight && i_tx_done;
  assign o_tx_en   = r_tx_en;
  assign o_tx_data = r_tx_data;

endmodule

// File: rtl/frame_uploader.sv
// Command-driven frame transfer: optional capture, FIFO rewind, then a framed
// UART packet of sync bytes, payload and 16-bit additive checksum.
module frame_uploader
  import frame_uploader_pkg::*;
#(
  parameter int IMG_BYTES      = 153600,
  parameter int TIMEOUT_CYCLES = 24000000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic       o_capture_start,
  input  logic       i_fifo_busy,
  output logic       o_read_start,
  input  logic       i_fifo_rrst_done,
  output logic       o_fifo_rd_byte_str,
  input  logic       i_data_ready,
  input  logic [7:0] i_data_from_fifo,
  output logic       o_busy,
  output logic       o_error
);

  localparam int CNT_W = $clog2(IMG_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t           r_state;
  logic             r_capture_start;
  logic             r_read_start;
  logic             r_rd_byte_str;
  logic             r_error;
  logic [7:0]       r_byte;
  logic [15:0]      r_csum;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_tx_req;
  logic [7:0]       w_tx_sel;
  logic             w_tx_done;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_tx_req = 1'b1;
    w_tx_sel = 8'h00;
    case (r_state)
      ST_HDR0:    w_tx_sel = SYNC0;
      ST_HDR1:    w_tx_sel = SYNC1;
      ST_BYTE_TX: w_tx_sel = r_byte;
      ST_CSUM_H:  w_tx_sel = r_csum[15:8];
      ST_CSUM_L:  w_tx_sel = r_csum[7:0];
      ST_ERR_TX:  w_tx_sel = ERR_CODE;
      default:    w_tx_req = 1'b0;
    endcase
  end

  uart_byte_issue u_issue (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_req     (w_tx_req),
    .i_data    (w_tx_sel),
    .i_tx_busy (i_tx_busy),
    .i_tx_done (i_tx_done),
    .o_tx_data (o_tx_data),
    .o_tx_en   (o_tx_en),
    .o_done    (w_tx_done)
  );

  // FIFO pulses are raised on the transition into their state so a command
  // reaches the FIFO one cycle after i_rx_done.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state         <= ST_IDLE;
      r_capture_start <= 1'b0;
      r_read_start    <= 1'b0;
      r_rd_byte_str   <= 1'b0;
      r_error         <= 1'b0;
      r_byte          <= 8'h00;
      r_csum          <= 16'h0000;
      r_cnt           <= '0;
      r_to_cnt        <= '0;
    end else begin
      r_capture_start <= 1'b0;
      r_read_start    <= 1'b0;
      r_rd_byte_str   <= 1'b0;
      r_to_cnt        <= r_to_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_rx_done && i_rx_data == CMD_CAPTURE) begin
            r_state         <= ST_CAP_START;
            r_capture_start <= 1'b1;
            r_error         <= 1'b0;
          end else if (i_rx_done && i_rx_data == CMD_READ) begin
            r_state      <= ST_RD_START;
            r_read_start <= 1'b1;
            r_error      <= 1'b0;
          end
        end
        ST_CAP_START: begin
          r_state  <= ST_CAP_WAIT_HI;
          r_to_cnt <= '0;
        end
        ST_CAP_WAIT_HI: begin
          if (i_fifo_busy) begin
            r_state  <= ST_CAP_WAIT_LO;
            r_to_cnt <= '0;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= ST_ERR_TX;
          end
        end
        ST_CAP_WAIT_LO: begin
          if (!i_fifo_busy) begin
            r_state      <= ST_RD_START;
            r_read_start <= 1'b1;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= ST_ERR_TX;
          end
        end
        ST_RD_START: begin
          r_state  <= ST_RRST_WAIT;
          r_to_cnt <= '0;
        end
        ST_RRST_WAIT: begin
          if (i_fifo_rrst_done) begin
            r_state <= ST_HDR0;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= ST_ERR_TX;
          end
        end
        ST_HDR0: begin
          if (w_tx_done) r_state <= ST_HDR1;
        end
        ST_HDR1: begin
          r_csum <= 16'h0000;
          r_cnt  <= '0;
          if (w_tx_done) r_state <= ST_BYTE_REQ;
        end
        ST_BYTE_REQ: begin
          r_rd_byte_str <= 1'b1;
          r_state       <= ST_BYTE_WAIT;
          r_to_cnt      <= '0;
        end
        ST_BYTE_WAIT: begin
          // A ready pulse coincident with our own strobe belongs to no request.
          if (i_data_ready && !r_rd_byte_str) begin
            r_byte  <= i_data_from_fifo;
            r_csum  <= r_csum + {8'h00, i_data_from_fifo};
            r_state <= ST_BYTE_TX;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= ST_ERR_TX;
          end
        end
        ST_BYTE_TX: begin
          if (w_tx_done) begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == CNT_W'(IMG_BYTES)) ? ST_CSUM_H : ST_BYTE_REQ;
          end
        end
        ST_CSUM_H: begin
          if (w_tx_done) r_state <= ST_CSUM_L;
        end
        ST_CSUM_L: begin
          if (w_tx_done) r_state <= ST_IDLE;
        end
        ST_ERR_TX: begin
          if (w_tx_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_capture_start    = r_capture_start;
  assign o_read_start       = r_read_start;
  assign o_fifo_rd_byte_str = r_rd_byte_str;
  assign o_error            = r_error;
  assign o_busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_frame_uploader.sv
// Directed-sequence bench with camera, FIFO and UART models; packets are checked
// against a sum-of-payload reference built from the stimulus array.
module tb_frame_uploader;
  import frame_uploader_pkg::*;

  localparam int IMG    = 300;
  localparam int TO     = 200;
  localparam int TX_LEN = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       uart_busy = 1'b0;
  logic       busy_hold = 1'b0;
  logic       tx_busy;
  logic       fifo_busy = 1'b0;
  logic       rrst_done = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] fifo_data = 8'h00;

  logic [7:0] o_tx_data;
  logic       o_tx_en, o_capture_start, o_read_start, o_fifo_rd_byte_str, o_busy, o_error;

  assign tx_busy = uart_busy | busy_hold;

  frame_uploader #(.IMG_BYTES(IMG), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_rx_done          (rx_done),
    .i_rx_data          (rx_data),
    .o_tx_data          (o_tx_data),
    .o_tx_en            (o_tx_en),
    .i_tx_busy          (tx_busy),
    .i_tx_done          (tx_done),
    .o_capture_start    (o_capture_start),
    .i_fifo_busy        (fifo_busy),
    .o_read_start       (o_read_start),
    .i_fifo_rrst_done   (rrst_done),
    .o_fifo_rd_byte_str (o_fifo_rd_byte_str),
    .i_data_ready       (data_ready),
    .i_data_from_fifo   (fifo_data),
    .o_busy             (o_busy),
    .o_error            (o_error)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cap_cnt = 0, rd_cnt = 0, str_cnt = 0;
  int lat_bad = 0, stab_bad = 0, en_busy_bad = 0;
  int uart_cnt = 0, rrst_pend = 0, rd_pend = 0, cap_pend = 0, busy_left = 0;
  int fifo_idx = 0, rdy_cyc = 0;
  bit rdy_pend = 0, cam_alive = 1;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] payload [IMG];
  logic [7:0] tx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter: records each byte, busy for TX_LEN cycles, then tx_done.
  initial forever begin
    @(posedge clk); #1;
    tx_done = 1'b0;
    if (o_tx_en) begin
      if (tx_busy) en_busy_bad++;
      if (rdy_pend && (cyc - rdy_cyc) != 2) lat_bad++;
      rdy_pend = 0;
      tx_q.push_back(o_tx_data);
      cur_byte  = o_tx_data;
      uart_busy = 1'b1;
      uart_cnt  = TX_LEN;
    end else if (uart_busy) begin
      if (o_tx_data !== cur_byte) stab_bad++;
      if (uart_cnt == 0) begin
        uart_busy = 1'b0;
        tx_done   = 1'b1;
      end else begin
        uart_cnt--;
      end
    end
  end

  // FIFO read side: rewind acknowledge and per-strobe data with random latency.
  initial forever begin
    @(posedge clk); #1;
    data_ready = 1'b0;
    rrst_done  = 1'b0;
    if (o_read_start) begin
      rd_cnt++;
      rrst_pend = 3;
      fifo_idx  = 0;
    end else if (rrst_pend > 0) begin
      rrst_pend--;
      if (rrst_pend == 0) rrst_done = 1'b1;
    end
    if (o_fifo_rd_byte_str) begin
      str_cnt++;
      rd_pend = $urandom_range(1, 3);
    end else if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        data_ready = 1'b1;
        fifo_data  = (fifo_idx < IMG) ? payload[fifo_idx] : 8'h00;
        fifo_idx++;
        rdy_pend = 1;
        rdy_cyc  = cyc;
      end
    end
  end

  // Camera capture: busy for 100 cycles shortly after the trigger, unless dead.
  initial forever begin
    @(posedge clk); #1;
    if (o_capture_start) begin
      cap_cnt++;
      if (cam_alive) cap_pend = 4;
    end else if (cap_pend > 0) begin
      cap_pend--;
      if (cap_pend == 0) begin
        fifo_busy = 1'b1;
        busy_left = 100;
      end
    end else if (fifo_busy) begin
      busy_left--;
      if (busy_left == 0) fifo_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qat(input int i);
    return (i < tx_q.size()) ? tx_q[i] : 8'h00;
  endfunction

  task automatic send_cmd(input logic [7:0] b, output logic cap_p, output logic rd_p);
    @(posedge clk); #2;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #2;
    rx_done = 1'b0;
    cap_p = o_capture_start;
    rd_p  = o_read_start;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_packet(input string tag);
    logic [7:0]  exp_q [$];
    logic [15:0] s = 16'h0000;
    int bad = -1;
    exp_q.push_back(SYNC0);
    exp_q.push_back(SYNC1);
    for (int i = 0; i < IMG; i++) begin
      exp_q.push_back(payload[i]);
      s += {8'h00, payload[i]};
    end
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    check({tag, "_len"}, tx_q.size(), exp_q.size());
    if (tx_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++)
        if (tx_q[i] !== exp_q[i] && bad < 0) bad = i;
    check({tag, "_first_bad_idx"}, bad, -1);
    $display("packet %s: %0d bytes, csum=%04h", tag, tx_q.size(), s);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < IMG; i++) payload[i] = 8'($urandom);
  endtask

  initial begin
    logic cp, rp;
    int s_cap, s_rd, s_str, n;

    randomize_payload();
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {15'd0, o_tx_data, o_tx_en, o_capture_start, o_read_start,
                            o_fifo_rd_byte_str, o_busy, o_error}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    // Read of an already captured frame.
    tx_q.delete();
    s_cap = cap_cnt; s_str = str_cnt;
    send_cmd(CMD_READ, cp, rp);
    check("r_read_start_latency", {31'd0, rp}, 32'd1);
    check("r_no_capture_pulse", {31'd0, cp}, 32'd0);
    wait_idle("r", 20000);
    check_packet("r_rand");
    check("r_strobes", str_cnt - s_str, IMG);
    check("r_no_capture", cap_cnt - s_cap, 0);
    check("r_error", {31'd0, o_error}, 32'd0);
    check("r_uart_idle_at_end", {31'd0, uart_busy}, 32'd0);

    // Capture then upload of an all-0xFF frame.
    for (int i = 0; i < IMG; i++) payload[i] = 8'hFF;
    tx_q.delete();
    s_cap = cap_cnt; s_str = str_cnt;
    send_cmd(CMD_CAPTURE, cp, rp);
    check("c_capture_latency", {31'd0, cp}, 32'd1);
    wait_idle("c", 20000);
    check("c_one_capture", cap_cnt - s_cap, 1);
    check("c_strobes", str_cnt - s_str, IMG);
    check("c_csum_hi", qat(IMG + 2), 8'h2A);
    check("c_csum_lo", qat(IMG + 3), 8'hD4);
    check_packet("c_ff");

    // Dead camera: capture wait times out into an error reply.
    cam_alive = 0;
    tx_q.delete();
    s_rd = rd_cnt;
    send_cmd(CMD_CAPTURE, cp, rp);
    wait_idle("to", 2000);
    check("to_reply_len", tx_q.size(), 1);
    check("to_reply_byte", qat(0), ERR_CODE);
    check("to_error_set", {31'd0, o_error}, 32'd1);
    check("to_no_read_start", rd_cnt - s_rd, 0);
    cam_alive = 1;

    // Next accepted command clears the error.
    randomize_payload();
    tx_q.delete();
    send_cmd(CMD_READ, cp, rp);
    check("clr_error", {31'd0, o_error}, 32'd0);
    wait_idle("clr", 20000);
    check_packet("clr");

    // Unknown command ignored; commands during upload dropped.
    tx_q.delete();
    send_cmd(8'h58, cp, rp);
    repeat (5) @(posedge clk);
    #2;
    check("x_ignored_busy", {31'd0, o_busy}, 32'd0);
    check("x_ignored_tx", tx_q.size(), 0);
    randomize_payload();
    s_cap = cap_cnt; s_rd = rd_cnt;
    send_cmd(CMD_READ, cp, rp);
    repeat (400) @(posedge clk);
    send_cmd(CMD_READ, cp, rp);
    check("mid_r_dropped", {31'd0, rp}, 32'd0);
    send_cmd(CMD_CAPTURE, cp, rp);
    check("mid_c_dropped", {31'd0, cp}, 32'd0);
    wait_idle("mid", 20000);
    check_packet("mid");
    check("mid_no_capture", cap_cnt - s_cap, 0);
    check("mid_one_read_start", rd_cnt - s_rd, 1);

    // Reset during BYTE_WAIT, then a clean packet.
    randomize_payload();
    s_str = str_cnt;
    send_cmd(CMD_READ, cp, rp);
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #2;
      n++;
      if (o_fifo_rd_byte_str && (str_cnt - s_str) >= 10) break;
    end
    check("rst_reached_byte_wait", {31'd0, o_fifo_rd_byte_str}, 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_outputs_zero", {15'd0, o_tx_data, o_tx_en, o_capture_start, o_read_start,
                               o_fifo_rd_byte_str, o_busy, o_error}, 32'd0);
    rd_pend = 0; rrst_pend = 0; rdy_pend = 0;
    tx_q.delete();
    @(negedge clk) rstn = 1'b1;
    randomize_payload();
    send_cmd(CMD_READ, cp, rp);
    wait_idle("rst", 20000);
    check_packet("after_rst");

    // Transmitter held busy before the first sync byte.
    randomize_payload();
    tx_q.delete();
    busy_hold = 1'b1;
    send_cmd(CMD_READ, cp, rp);
    repeat (500) @(posedge clk);
    #2;
    check("hold_no_tx", tx_q.size(), 0);
    check("hold_still_busy", {31'd0, o_busy}, 32'd1);
    busy_hold = 1'b0;
    wait_idle("hold", 20000);
    check("hold_first_sync", qat(0), SYNC0);
    check_packet("hold");

    check("tx_en_latency_2", lat_bad, 0);
    check("tx_data_stable", stab_bad, 0);
    check("tx_en_never_busy", en_busy_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_uploader.md
# frame_uploader

Command-driven frame transfer sequencer between `uart_rx`/`uart_tx` and `fifo_capture` in the OV7670/AL422B camera path. On a UART command it optionally triggers a FIFO frame capture, rewinds the FIFO read pointer, and pulls the image out one byte at a time. Each byte is streamed to `uart_tx` inside a framed packet: two sync bytes, the payload, and a 16-bit checksum. Timeouts on every FIFO wait convert a hung camera into a one-byte error reply instead of a lockup.

## Interface
Parameters:
- `IMG_BYTES`, 153600: payload bytes per frame (320x240 RGB565).
- `TIMEOUT_CYCLES`, 24000000: maximum i_clk cycles spent in any single FIFO wait state (1 s at 24 MHz).

Ports:
- `i_clk`  in  1  system clock, 24 MHz.
- `i_rstn`  in  1  asynchronous active-low reset.
- `i_rx_done`  in  1  one-cycle pulse; `i_rx_data` valid.
- `i_rx_data`  in  8  received command byte.
- `o_tx_data`  out  8  byte to transmit; held stable from `o_tx_en` until `i_tx_done`.
- `o_tx_en`  out  1  one-cycle transmit request.
- `i_tx_busy`  in  1  UART transmitter busy.
- `i_tx_done`  in  1  one-cycle pulse at end of stop bit.
- `o_capture_start`  out  1  one-cycle capture trigger to `fifo_capture`.
- `i_fifo_busy`  in  1  capture in progress.
- `o_read_start`  out  1  one-cycle read-pointer reset request.
- `i_fifo_rrst_done`  in  1  one-cycle pulse; read pointer reset complete.
- `o_fifo_rd_byte_str`  out  1  one-cycle byte read strobe.
- `i_data_ready`  in  1  one-cycle pulse; `i_data_from_fifo` valid.
- `i_data_from_fifo`  in  8  image byte.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_error`  out  1  sticky timeout flag; cleared by the next accepted command.

All outputs reset to 0.

## Operation
- Commands are accepted only in IDLE. Commands received in any other state are dropped.
  - `0x43` ('C'): capture, then upload.
  - `0x52` ('R'): upload the frame already in the FIFO, with no capture.
  - Any other byte is ignored.
- States and transitions:
  - IDLE: 'C' goes to CAP_START; 'R' goes to RD_START.
  - CAP_START: pulse `o_capture_start`, then CAP_WAIT_HI.
  - CAP_WAIT_HI: wait for `i_fifo_busy`=1, then CAP_WAIT_LO.
  - CAP_WAIT_LO: wait for `i_fifo_busy`=0, then RD_START.
  - RD_START: pulse `o_read_start`, then RRST_WAIT.
  - RRST_WAIT: wait for `i_fifo_rrst_done`, then HDR0.
  - HDR0: send 0xA5.
  - HDR1: send 0x5A, clear the checksum and byte counter.
  - BYTE_REQ: pulse `o_fifo_rd_byte_str`.
  - BYTE_WAIT: on `i_data_ready`, latch the byte, checksum += byte, go to BYTE_TX.
  - BYTE_TX: send the byte and increment the counter; go to CSUM_H if counter == IMG_BYTES, else back to BYTE_REQ.
  - CSUM_H: send checksum[15:8].
  - CSUM_L: send checksum[7:0], then IDLE.
  - ERR_TX: send 0xEE, then IDLE.
- Send procedure, used by every TX state:
  - Wait for `i_tx_busy`=0.
  - Drive `o_tx_data` and pulse `o_tx_en`.
  - Wait for `i_tx_done`, then advance.
- Checksum is the unsigned sum of payload bytes mod 2^16. Sync and checksum bytes are excluded.
- Byte counter width is $clog2(IMG_BYTES+1).
- Timeouts:
  - A timeout counter restarts on entry to each of CAP_WAIT_HI, CAP_WAIT_LO, RRST_WAIT and BYTE_WAIT.
  - Reaching TIMEOUT_CYCLES sets `o_error` and goes to ERR_TX.
  - TX waits have no timeout.

## Timing
- `o_capture_start`, `o_read_start`, `o_fifo_rd_byte_str` and `o_tx_en` are registered and exactly one cycle wide.
- Command to first FIFO pulse: 1 cycle. `i_rx_done` in cycle N gives the pulse in cycle N+1.
- `o_fifo_rd_byte_str` rises 1 cycle after entry to BYTE_REQ.
- `i_data_ready` arriving in the same cycle as the strobe is ignored. Only pulses seen in BYTE_WAIT count.
- `o_tx_en` for a payload byte follows its `i_data_ready` by 2 cycles when `i_tx_busy`=0.
- Simultaneous timeout expiry and `i_data_ready` (or any awaited event): the event wins.
- Asynchronous reset mid-transfer returns the block to IDLE with all outputs 0. The packet is truncated and no error byte is sent.

## Structure
- Package `frame_uploader_pkg` holds:
  - command codes CMD_CAPTURE=0x43 and CMD_READ=0x52;
  - sync bytes SYNC0=0xA5 and SYNC1=0x5A;
  - ERR_CODE=0xEE;
  - the state enum.
- The single sub-module `uart_byte_issue` implements the busy-check / tx_en pulse / tx_done wait handshake. It is instantiated once and shared by all TX states.

## Test plan
- 'R' with a FIFO model returning 0x01..0x04 and IMG_BYTES=4 -> UART stream A5 5A 01 02 03 04 00 0A; `o_busy` falls after the last `i_tx_done`.
- 'C' with `i_fifo_busy` high for 100 cycles, 0xFF payload, IMG_BYTES=300 -> exactly one `o_capture_start`, 300 strobes, checksum bytes 0x2A 0xD4.
- 'C' with `i_fifo_busy` never asserting and TIMEOUT_CYCLES=50 -> 0xEE sent, `o_error`=1, no `o_read_start`; a following 'R' clears `o_error`.
- 'X', then 'R' and 'C' injected mid-upload -> no effect; the packet completes unchanged.
- Reset asserted during BYTE_WAIT -> all outputs 0 within the same cycle; a fresh 'R' yields a complete, correct packet.
- `i_tx_busy` held high 500 cycles before HDR0 -> `o_tx_en` withheld until it drops, then A5 sent.
